// File: rtl/pw_bit_cfg_seq.sv
// pw_bit_cfg_seq: writes a NUM_REGS-word register image to an AXI4-Lite slave, highest index first.
// Define PW_BIT_CFG_AUTO_EN to add a free-running counter that restarts the sequence every AUTO_PERIOD cycles.
module pw_bit_cfg_seq #(
    parameter int AXI_ID_WIDTH   = 1,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 8,
    parameter int NUM_REGS       = 32,
    parameter int AUTO_PERIOD    = 3000,
    localparam int IDX_W         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    input  logic                        img_we,
    input  logic [IDX_W-1:0]            img_addr,
    input  logic [AXI_DATA_WIDTH-1:0]   img_wdata,
    output logic [AXI_ID_WIDTH-1:0]     m_axi_awid,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]                  m_axi_awprot,
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    input  logic [AXI_ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]                  m_axi_bresp,
    input  logic                        m_axi_bvalid,
    output logic                        m_axi_bready
);

    typedef enum logic [1:0] {IDLE, XFER, RESP, NEXT} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    state_t                    state;
    logic [IDX_W-1:0]          idx;
    logic [AXI_DATA_WIDTH-1:0] image [NUM_REGS];
    logic                      start_int;
    logic                      aw_fin;
    logic                      w_fin;
    logic                      unused_bid;

    assign m_axi_awid   = '0;
    assign m_axi_awprot = '0;
    assign m_axi_wstrb  = '1;
    assign unused_bid   = ^m_axi_bid;

    function automatic logic [AXI_ADDR_WIDTH-1:0] byte_addr(input logic [IDX_W-1:0] i);
        return AXI_ADDR_WIDTH'({i, 2'b00});
    endfunction

`ifdef PW_BIT_CFG_AUTO_EN
    logic [31:0] auto_cnt;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            auto_cnt <= 32'(AUTO_PERIOD - 1);
        end else if (auto_cnt == '0) begin
            auto_cnt <= 32'(AUTO_PERIOD - 1);
        end else begin
            auto_cnt <= auto_cnt - 1'b1;
        end
    end

    // A reload that lands while busy is dropped by the IDLE-only start decode below.
    assign start_int = start | (auto_cnt == '0);
`else
    localparam int unused_auto_period = AUTO_PERIOD;
    assign start_int = start;
`endif

    // The image is frozen while a sequence runs so every word sent belongs to the same snapshot.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                image[i] <= '0;
            end
        end else if (img_we && !busy && (32'(img_addr) < NUM_REGS)) begin
            image[img_addr] <= img_wdata;
        end
    end

    assign aw_fin = !m_axi_awvalid || m_axi_awready;
    assign w_fin  = !m_axi_wvalid  || m_axi_wready;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state         <= IDLE;
            idx           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_wdata   <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_int) begin
                        idx           <= LAST_IDX;
                        err           <= 1'b0;
                        busy          <= 1'b1;
                        m_axi_awaddr  <= byte_addr(LAST_IDX);
                        m_axi_wdata   <= image[LAST_IDX];
                        m_axi_awvalid <= 1'b1;
                        m_axi_wvalid  <= 1'b1;
                        state         <= XFER;
                    end
                end
                XFER: begin
                    if (m_axi_awvalid && m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                    end
                    if (m_axi_wvalid && m_axi_wready) begin
                        m_axi_wvalid <= 1'b0;
                    end
                    if (aw_fin && w_fin) begin
                        m_axi_bready <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        if (m_axi_bresp != 2'b00) begin
                            err <= 1'b1;
                        end
                        if (idx != '0) begin
                            state <= NEXT;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                NEXT: begin
                    idx           <= idx - 1'b1;
                    m_axi_awaddr  <= byte_addr(idx - 1'b1);
                    m_axi_wdata   <= image[idx - 1'b1];
                    m_axi_awvalid <= 1'b1;
                    m_axi_wvalid  <= 1'b1;
                    state         <= XFER;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
